dev_btn_in: RTL

Debounced push-button input device, the input-side counterpart of the hex display output device in the I/O interface. Synchronises up to four raw button pins and debounces each with a per-button stability counter. Latches press events until the CPU-side read port consumes them. Sits on the same byte-wide device bus as the display and exposes a level-sensitive event flag for polling or interrupt use.

---
 rtl/dev_btn_pkg.sv | 15 +
 rtl/dev_btn_debounce.sv | 59 +++++
 rtl/dev_btn_in.sv | 64 ++++++
 3 files changed

// File: rtl/dev_btn_pkg.sv
// Shared constants and the read-word layout for the push-button input device.
package dev_btn_pkg;

    localparam int BTN_MAX          = 4;
    localparam int DEBOUNCE_DEFAULT = 120000;
    localparam int RD_LEVEL_LSB     = 0;
    localparam int RD_PENDING_LSB   = 4;

    // Byte returned on the device bus; pending sits in the upper nibble.
    typedef struct packed {
        logic [BTN_MAX-1:0] pending;
        logic [BTN_MAX-1:0] level;
    } rd_word_t;

endpackage

// File: rtl/dev_btn_debounce.sv
// One button: 2-FF synchroniser, stability counter, debounced level and
// a one-cycle press pulse on each accepted 0->1 transition.
module dev_btn_debounce
    import dev_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          q1_q, q1_d;
    logic          q2_q, q2_d;
    logic          stable_q, stable_d;
    logic          stable_dly_q, stable_dly_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where q2 agrees with stable restarts the window from zero.
    always_comb begin
        q1_d         = pin;
        q2_d         = q1_q;
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        cnt_d        = '0;
        if (q2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = q2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_q         <= 1'b0;
            q2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            q1_q         <= q1_d;
            q2_q         <= q2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = stable_q;
    assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/dev_btn_in.sv
// Debounced push-button device on the byte-wide bus: latches presses until
// read, returns {pending, level} one cycle after rd, flags pending via evt.
module dev_btn_in
    import dev_btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_pins,
    input  logic             rd,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             evt,
    output logic [N_BTN-1:0] level
);

    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] pending_q, pending_d;
    rd_word_t         rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        dev_btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .pin   (btn_pins[gi]),
            .level (level[gi]),
            .press (press[gi])
        );
    end

    // A press in the read cycle is OR'd in after the clear so it is never lost.
    always_comb begin
        pending_d  = (rd ? '0 : pending_q) | press;
        rd_valid_d = rd;
        rd_data_d  = rd_data_q;
        if (rd) begin
            rd_data_d                     = '0;
            rd_data_d.pending[N_BTN-1:0]  = pending_q;
            rd_data_d.level[N_BTN-1:0]    = level;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign evt      = |pending_q;

endmodule
